// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler with spike event FIFO.
// Optional total spike counter enabled by define IZH_SCHED_SPIKE_CNT_EN.
module izh_neuron_scheduler #(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = $clog2(N_NEURONS),
  parameter int DP_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tick,
  output logic             busy,
  output logic             sweep_done,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [17:0]      dp_v,
  output logic [17:0]      dp_u,
  output logic [3:0]       dp_type,
  output logic [7:0]       dp_current,
  output logic             dp_valid,
  input  logic [17:0]      dp_v_next,
  input  logic [17:0]      dp_u_next,
  input  logic             dp_spike,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic             evt_overflow,
  output logic             tick_overrun,
  input  logic [IDX_W-1:0] mon_idx,
  output logic [7:0]       mon_v,
  output logic [15:0]      spike_cnt
);

  localparam int CW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [17:0] V_RST = 18'h34CCD;
  localparam logic [17:0] U_RST = 18'h3CCCD;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    cnt;
  logic             pending;

  logic [17:0] v_mem [N_NEURONS];
  logic [17:0] u_mem [N_NEURONS];
  logic [3:0]  t_mem [N_NEURONS];
  logic [7:0]  c_mem [N_NEURONS];

  logic [IDX_W-1:0] fifo [FIFO_DEPTH];
  logic [FW:0]      wp, rp;

  logic             clr, cfg_ok, mon_ok;
  logic             last, last_n, wb, push, pop, full;
  logic             ld_first, ld_next, ld, start;
  logic [IDX_W-1:0] ld_idx;

  assign clr    = cfg_we && (cfg_sel == 2'd2);
  assign cfg_ok = 32'(cfg_addr) < N_NEURONS;
  assign mon_ok = 32'(mon_idx) < N_NEURONS;
  assign last   = cnt == CW'(DP_LAT);
  assign last_n = idx == IDX_W'(N_NEURONS - 1);
  assign wb     = ena && (state == EVAL) && last;
  assign push   = wb && dp_spike;

  assign evt_valid = wp != rp;
  assign full      = (wp[FW] != rp[FW]) && (wp[FW-1:0] == rp[FW-1:0]);
  assign pop       = evt_ready && evt_valid;
  assign evt_idx   = fifo[rp[FW-1:0]];

  assign start    = (state == DONE) ? (pending || tick) : tick;
  assign ld_first = ena && (state != EVAL) && start;
  assign ld_next  = wb && !last_n;
  assign ld       = ld_first || ld_next;
  assign ld_idx   = ld_first ? '0 : idx + 1'b1;

  assign mon_v = mon_ok ? v_mem[mon_idx][17:10] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      pending      <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (clr) tick_overrun <= 1'b0;
      if (ena) begin
        unique case (state)
          IDLE: if (tick) begin
            state <= EVAL;
            busy  <= 1'b1;
            idx   <= '0;
            cnt   <= '0;
          end
          EVAL: begin
            if (tick) begin
              if (pending) tick_overrun <= 1'b1;
              else pending <= 1'b1;
            end
            if (last) begin
              cnt <= '0;
              if (last_n) begin
                state      <= DONE;
                sweep_done <= 1'b1;
              end else begin
                idx <= ld_idx;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: if (start) begin
            // queued tick restarts the sweep without visiting IDLE
            state   <= EVAL;
            pending <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            if (pending && tick) tick_overrun <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v       <= '0;
      dp_u       <= '0;
      dp_type    <= '0;
      dp_current <= '0;
      dp_valid   <= 1'b0;
    end else begin
      dp_valid <= ld;
      if (ld) begin
        dp_v       <= v_mem[ld_idx];
        dp_u       <= u_mem[ld_idx];
        dp_type    <= t_mem[ld_idx];
        dp_current <= c_mem[ld_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= V_RST;
        u_mem[i] <= U_RST;
        t_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      if (wb) begin
        v_mem[idx] <= dp_v_next;
        u_mem[idx] <= dp_u_next;
      end
      if (cfg_we && cfg_ok && (cfg_sel == 2'd0)) t_mem[cfg_addr] <= cfg_data[3:0];
      if (cfg_we && cfg_ok && (cfg_sel == 2'd1)) c_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp           <= '0;
      rp           <= '0;
      evt_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (clr) evt_overflow <= 1'b0;
      if (push && (!full || pop)) begin
        fifo[wp[FW-1:0]] <= idx;
        wp               <= wp + 1'b1;
      end else if (push) begin
        evt_overflow <= 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

`ifdef IZH_SCHED_SPIKE_CNT_EN
  logic [15:0] scnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt <= '0;
    else if (clr || push) scnt <= (clr ? 16'h0 : scnt) + 16'(push);
  end
  assign spike_cnt = scnt;
`else
  assign spike_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler (N=8, DP_LAT=1, FIFO_DEPTH=4).
// Datapath model: v+1, u unchanged, spike on current 8'h55 or spike_all.
module tb_izh_neuron_scheduler;

`ifdef IZH_SCHED_SPIKE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 0, rst_n = 0, ena = 0, tick = 0;
  logic        busy, sweep_done, dp_valid, dp_spike;
  logic        cfg_we = 0;
  logic [1:0]  cfg_sel = 0;
  logic [2:0]  cfg_addr = 0, evt_idx, mon_idx = 3;
  logic [7:0]  cfg_data = 0, dp_current, mon_v;
  logic [17:0] dp_v, dp_u, dp_v_next, dp_u_next;
  logic [3:0]  dp_type;
  logic        evt_valid, evt_ready = 0, evt_overflow, tick_overrun;
  logic [15:0] spike_cnt;
  logic        spike_all = 0;

  izh_neuron_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
    .busy(busy), .sweep_done(sweep_done),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dp_v(dp_v), .dp_u(dp_u), .dp_type(dp_type),
    .dp_current(dp_current), .dp_valid(dp_valid),
    .dp_v_next(dp_v_next), .dp_u_next(dp_u_next),
    .dp_spike(dp_spike),
    .evt_valid(evt_valid), .evt_idx(evt_idx),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow),
    .tick_overrun(tick_overrun), .mon_idx(mon_idx),
    .mon_v(mon_v), .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  assign dp_v_next = dp_v + 18'd1;
  assign dp_u_next = dp_u;
  assign dp_spike  = spike_all || (dp_current == 8'h55);

  int          vectors = 0, misses = 0;
  int          log_n = 0;
  logic [17:0] log_v [64];
  logic [17:0] log_u [64];
  logic [3:0]  log_t [64];
  logic [7:0]  log_c [64];

  always @(negedge clk) begin
    if (dp_valid && log_n < 64) begin
      log_v[log_n] = dp_v;
      log_u[log_n] = dp_u;
      log_t[log_n] = dp_type;
      log_c[log_n] = dp_current;
      log_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [2:0] a,
                     input logic [7:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  logic [17:0] frz_v;
  logic        frz_b;
  logic [3:0]  frz_t;

  task automatic sweep(input int frz_at, input bit tk, input int cfg_at,
                       output int nbusy, output int ndone,
                       output int done_at);
    nbusy = 0; ndone = 0; done_at = 0; log_n = 0;
    tick = 1;
    step();
    tick = 0;
    for (int c = 1; c <= 120; c++) begin
      if (busy) nbusy++;
      if (sweep_done) begin ndone++; done_at = c; end
      tick = tk && (c == 3 || c == 5 || c == 7);
      if (frz_at > 0 && c == frz_at) ena = 0;
      if (frz_at > 0 && c == frz_at + 5) begin
        frz_v = dp_v; frz_b = busy; ena = 1;
      end
      if (cfg_at > 0 && c == cfg_at) begin
        cfg_we = 1; cfg_sel = 0; cfg_addr = 3; cfg_data = 8'h05;
      end
      if (cfg_at > 0 && c == cfg_at + 1) begin
        cfg_we = 0; frz_t = dp_type;
      end
      if (!busy) break;
      step();
    end
    tick = 0;
  endtask

  int nb, nd, da;

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);
    check("rst_evt", evt_valid, 0);
    check("rst_dpv", dp_v, 0);
    check("rst_monv", mon_v, 8'hD3);
    check("rst_cnt", spike_cnt, 0);
    rst_n = 1;
    step();
    ena = 1;

    // 1: plain sweep timing and v+1 writeback
    sweep(0, 0, 0, nb, nd, da);
    check("t1_busy", nb, 17);
    check("t1_ndone", nd, 1);
    check("t1_doneat", da, 17);
    check("t1_logn", log_n, 8);
    check("t1_v0", log_v[0], 18'h34CCD);
    check("t1_u4", log_u[4], 18'h3CCCD);

    // 2: neurons 2 and 5 spike
    cfg(1, 2, 8'h55);
    cfg(1, 5, 8'h55);
    sweep(0, 0, 0, nb, nd, da);
    check("t2_v0", log_v[0], 18'h34CCE);
    check("t2_v7", log_v[7], 18'h34CCE);
    check("t2_c5", log_c[5], 8'h55);
    check("t2_valid", evt_valid, 1);
    check("t2_head0", evt_idx, 2);
    check("t2_cnt", spike_cnt, CNT_ON ? 2 : 0);
    evt_ready = 1;
    step();
    check("t2_head1", evt_idx, 5);
    check("t2_valid1", evt_valid, 1);
    step();
    check("t2_empty", evt_valid, 0);
    evt_ready = 0;

    // 3: every neuron spikes into a 4-deep FIFO
    cfg(2, 0, 0);
    spike_all = 1;
    sweep(0, 0, 0, nb, nd, da);
    check("t3_v3", log_v[3], 18'h34CCF);
    check("t3_ovf", evt_overflow, 1);
    check("t3_cnt", spike_cnt, CNT_ON ? 8 : 0);
    cfg(2, 0, 0);
    check("t3_ovfclr", evt_overflow, 0);
    check("t3_cntclr", spike_cnt, 0);
    evt_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check("t3_valid", evt_valid, 1);
      check("t3_idx", evt_idx, k);
      step();
    end
    check("t3_empty", evt_valid, 0);
    step();
    check("t3_empty2", evt_valid, 0);
    evt_ready = 0;
    spike_all = 0;
    cfg(1, 2, 0);
    cfg(1, 5, 0);

    // 4: three extra ticks during one sweep
    sweep(0, 1, 0, nb, nd, da);
    check("t4_busy", nb, 34);
    check("t4_ndone", nd, 2);
    check("t4_doneat", da, 34);
    check("t4_ovr", tick_overrun, 1);
    check("t4_logn", log_n, 16);
    check("t4_v8", log_v[8], 18'h34CD1);
    cfg(2, 0, 0);
    check("t4_ovrclr", tick_overrun, 0);
    check("t4_evt", evt_valid, 0);

    // 5: ena low for 5 cycles while neuron 3 is evaluated
    sweep(7, 0, 0, nb, nd, da);
    check("t5_busy", nb, 22);
    check("t5_doneat", da, 22);
    check("t5_frzv", frz_v, 18'h34CD2);
    check("t5_frzb", frz_b, 1);
    check("t5_logn", log_n, 8);

    // 6: type write to neuron 3 mid-evaluation
    sweep(0, 0, 7, nb, nd, da);
    check("t6_v7", log_v[7], 18'h34CD3);
    check("t6_tfrz", frz_t, 0);
    check("t6_told", log_t[3], 0);
    sweep(0, 0, 0, nb, nd, da);
    check("t6_tnew", log_t[3], 4'h5);
    check("t6_t2", log_t[2], 0);
    check("t6_v0", log_v[0], 18'h34CD4);

    // async reset mid-sweep
    tick = 1;
    step();
    tick = 0;
    step();
    step();
    #2 rst_n = 0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_dpv", dp_v, 0);
    check("ar_monv", mon_v, 8'hD3);
    step();
    rst_n = 1;
    step();
    sweep(0, 0, 0, nb, nd, da);
    check("ar_v0", log_v[0], 18'h34CCD);
    check("ar_t3", log_t[3], 0);
    check("ar_busy17", nb, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
